replay_buffer: RTL and testbench
================================

Name: replay_buffer

Overview:
- Transaction-layer replay buffer for a PCIe-style link.
- Stores each outgoing 128-bit TLP with its 12-bit sequence number and serialises it onto a 16-bit output.
- Keeps each TLP until it is acknowledged.
- Replays unacknowledged TLPs on NAK or replay-timer timeout.
- Sits between the TLP generator and the data-link transmit path.

Parameters:
- DEPTH, 8, number of TLP slots (power of two).
- AW, 3, slot pointer width, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset; one clock, reset is synchronous and active-low.
- busy_n  input  1  link ready; 0 = stall the output word stream.
- ack_nack  input  2  01 = ACK, 10 = NAK, 00/11 = no action.
- seq  input  12  sequence number; tags the TLP on we, and is the AckNak_Seq_Num on ACK/NAK.
- tim_out  input  1  replay-timer expiry pulse.
- ready  output  1  buffer can accept a new TLP.
- we  input  1  write strobe for din.
- din  input  128  TLP to store and transmit.
- dout  output  16  serialised TLP word.

Positional declaration order: busy_n, clk, reset_n, ack_nack, seq, tim_out, ready, we, din, dout.

Behaviour:
- Storage: DEPTH x (128-bit data + 12-bit seq).
- Registers: wr_ptr, rd_ptr (oldest unacked), cnt (0..DEPTH), word index w (0..7), replay pointer rp, replay remaining rr.
- Reset (reset_n=0 at a clock edge): state=IDLE, wr_ptr=rd_ptr=cnt=w=0, dout=0, ready=1. Storage contents are don't-care. Reset mid-transmission aborts immediately.
- States: IDLE, TX, PURGE, REPLAY.
- dout is combinational: word w of the selected slot in TX/REPLAY, else 16'h0000. Word 0 = data[127:112] and word 7 = data[15:0] (MSW first).
- ready = (state==IDLE) && (cnt<DEPTH).
- IDLE event priority: tim_out > NAK > ACK > we. Only one event is taken per cycle; lower-priority events in the same cycle are dropped.
- we with ready=1:
  - Write din and seq into slot wr_ptr.
  - wr_ptr++, cnt++, w=0, go to TX.
  - dout shows word 0 in the cycle after the we edge.
- we with ready=0: ignored, nothing stored.
- TX:
  - At each edge with busy_n=1: w++.
  - At w=7 with busy_n=1: go to IDLE.
  - busy_n=0: hold w, dout holds its value.
  - A clean transfer takes exactly 8 cycles.
- ACK in IDLE:
  - Latch seq as ackseq, go to PURGE.
  - PURGE releases one entry per cycle: while cnt>0 and the oldest entry is covered, rd_ptr++ and cnt--.
  - Covered means ((ackseq - entry_seq) mod 4096) < 2048.
  - Go to IDLE when cnt==0 or the oldest entry is not covered.
  - An ACK that covers nothing costs one PURGE cycle and changes nothing.
- NAK in IDLE:
  - Perform the same purge as ACK.
  - Then, if cnt>0, enter REPLAY with rp=rd_ptr, rr=cnt, w=0; else go to IDLE.
- tim_out in IDLE: if cnt>0, enter REPLAY with rp=rd_ptr, rr=cnt, w=0. No purge.
- REPLAY:
  - Streams slot rp exactly like TX, with the same busy_n stall rule.
  - After word 7 is accepted: rp++ and rr--. If rr becomes 0 go to IDLE, else w=0 and continue.
  - Replay does not modify rd_ptr or cnt; entries stay held until ACKed.
- Events arriving outside IDLE (we, ack_nack, tim_out) are ignored. The upstream block must hold or re-issue them.
- Pointers wrap modulo DEPTH. Sequence compare wraps modulo 4096.
- Full (cnt==DEPTH): ready=0; ACK, NAK and tim_out are still serviced.
- Empty: tim_out has no effect; NAK after purge returns to IDLE.

Test Plan:
- Reset then store:
  - Stimulus: reset_n low 1 cycle, then we=1 with seq=0 and din=128'h400000010000000ffdaff04012345678, busy_n=1.
  - Required: dout sequence 4000,0001,0000,000f,fdaf,f040,1234,5678 on the next 8 cycles, then 0000; ready=0 during TX, 1 after.
- Stall:
  - Stimulus: same TLP, busy_n=0 for 3 cycles while dout=000f.
  - Required: dout holds 000f for 3 extra cycles; total 11 cycles.
- ACK:
  - Stimulus: store seq 0,1,2, then ACK with seq=1.
  - Required: cnt 3->1; a following tim_out replays only the seq 2 TLP (8 words) and returns to IDLE.
- NAK:
  - Stimulus: store seq 0..3, then NAK with seq=0.
  - Required: seq 0 purged; seq 1,2,3 replayed back-to-back (24 words, in order); cnt=3 afterwards.
- Full:
  - Stimulus: store 8 TLPs.
  - Required: ready=0; a 9th we is ignored; ACK with seq=7 empties the buffer and ready returns to 1.
- Priority and wrap:
  - Stimulus: tim_out and we in the same IDLE cycle.
  - Required: replay starts and we is dropped.
  - Stimulus: entry seq=4095, ACK seq=0.
  - Required: the entry is released.

Source files
------------

// File: rtl/replay_buffer.sv
// Replay buffer: holds outgoing TLPs until ACKed, serialises them MSW-first,
// and replays the unacknowledged backlog on NAK or replay-timer expiry.
module replay_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         busy_n,
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   ack_nack,
    input  logic [11:0]  seq,
    input  logic         tim_out,
    output logic         ready,
    input  logic         we,
    input  logic [127:0] din,
    output logic [15:0]  dout
);

    typedef enum logic [1:0] {IDLE, TX, PURGE, REPLAY} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t         state_q;
    logic [127:0]   data_mem [DEPTH];
    logic [11:0]    seq_mem  [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW-1:0]  rp_q;
    logic [AW:0]    cnt_q;
    logic [AW:0]    rr_q;
    logic [2:0]     w_q;
    logic [11:0]    ackseq_q;
    logic           nak_q;

    logic           is_ack;
    logic           is_nak;
    logic           wr_en;
    logic           covered;
    logic [11:0]    seq_diff;
    logic [127:0]   word_sel;

    assign is_ack   = (ack_nack == 2'b01);
    assign is_nak   = (ack_nack == 2'b10);
    assign ready    = (state_q == IDLE) && (cnt_q < FULL);
    assign wr_en    = ready && we && !tim_out && !is_ack && !is_nak;

    // Oldest entry is released when it lies in the half-window behind ackseq.
    assign seq_diff = ackseq_q - seq_mem[rd_ptr_q];
    assign covered  = !seq_diff[11];

    assign word_sel = data_mem[rp_q];
    assign dout     = (state_q == TX || state_q == REPLAY)
                    ? word_sel[{~w_q, 4'b0000} +: 16] : 16'h0000;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q] <= din;
            seq_mem[wr_ptr_q]  <= seq;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            w_q      <= '0;
            ackseq_q <= '0;
            nak_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tim_out) begin
                        if (cnt_q != '0) begin
                            state_q <= REPLAY;
                            rp_q    <= rd_ptr_q;
                            rr_q    <= cnt_q;
                            w_q     <= '0;
                        end
                    end else if (is_nak || is_ack) begin
                        ackseq_q <= seq;
                        nak_q    <= is_nak;
                        state_q  <= PURGE;
                    end else if (wr_en) begin
                        rp_q     <= wr_ptr_q;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        cnt_q    <= cnt_q + 1'b1;
                        w_q      <= '0;
                        state_q  <= TX;
                    end
                end
                TX: begin
                    if (busy_n) begin
                        w_q <= w_q + 1'b1;
                        if (w_q == 3'd7) state_q <= IDLE;
                    end
                end
                PURGE: begin
                    if (cnt_q != '0 && covered) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        cnt_q    <= cnt_q - 1'b1;
                    end else if (nak_q && cnt_q != '0) begin
                        state_q <= REPLAY;
                        rp_q    <= rd_ptr_q;
                        rr_q    <= cnt_q;
                        w_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REPLAY: begin
                    if (busy_n) begin
                        w_q <= w_q + 1'b1;
                        if (w_q == 3'd7) begin
                            rp_q <= rp_q + 1'b1;
                            rr_q <= rr_q - 1'b1;
                            if (rr_q == ONE) state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replay_buffer.sv
// Scenario bench for replay_buffer: expected words are queued when TLPs are
// issued and popped as the serialised stream appears on dout.
module tb_replay_buffer;

    logic         busy_n;
    logic         clk;
    logic         reset_n;
    logic [1:0]   ack_nack;
    logic [11:0]  seq;
    logic         tim_out;
    logic         ready;
    logic         we;
    logic [127:0] din;
    logic [15:0]  dout;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp;

    localparam logic [127:0] TLP0 = 128'h400000010000000ffdaff04012345678;

    replay_buffer #(.DEPTH(8), .AW(3)) dut (
        .busy_n(busy_n), .clk(clk), .reset_n(reset_n), .ack_nack(ack_nack),
        .seq(seq), .tim_out(tim_out), .ready(ready), .we(we), .din(din),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] tlp(input int i);
        logic [15:0] k;
        k = 16'(i);
        return {8{k}} ^ 128'hA0001111222233334444555566667777;
    endfunction

    task automatic push_tlp(input logic [127:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[127-16*i -: 16]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns on the negedge where word 0 of the new TLP is visible.
    task automatic send_start(input logic [11:0] s, input logic [127:0] d);
        @(negedge clk);
        we = 1'b1; seq = s; din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic send(input logic [11:0] s, input logic [127:0] d);
        send_start(s, d);
        repeat (8) @(negedge clk);
    endtask

    task automatic send_ack(input logic [1:0] a, input logic [11:0] s);
        @(negedge clk);
        ack_nack = a; seq = s;
        @(negedge clk);
        ack_nack = 2'b00;
    endtask

    task automatic pulse_to();
        @(negedge clk);
        tim_out = 1'b1;
        @(negedge clk);
        tim_out = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 30) begin
            bad++;
            $display("FAIL %s ready timeout got=%b want=1", nm, ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ready !== 1'b1 || dout !== 16'h0) begin
            bad++;
            $display("FAIL reset_state ready=%b dout=%h want 1/0000", ready, dout);
        end
        send_start(12'd0, TLP0);
        repeat (3) @(negedge clk);
        do_reset();
        total++;
        if (ready !== 1'b1 || dout !== 16'h0) begin
            bad++;
            $display("FAIL reset_abort ready=%b dout=%h want 1/0000", ready, dout);
        end
        pulse_to();
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_empty_to dout=%h ready=%b want 0000/1", dout, ready);
        end
    endtask

    task automatic test_store();
        do_reset();
        send_start(12'd0, TLP0);
        push_tlp(TLP0);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp || ready !== 1'b0) begin
                bad++;
                $display("FAIL store_word dout=%h ready=%b want %h/0", dout, ready, exp);
            end
            @(negedge clk);
        end
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL store_end dout=%h ready=%b want 0000/1", dout, ready);
        end
    endtask

    task automatic test_stall();
        int i = 0;
        do_reset();
        send_start(12'd0, TLP0);
        push_tlp(TLP0);
        repeat (3) exp_q.insert(3, 16'h000f);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL stall_word%0d dout=%h want=%h", i, dout, exp);
            end
            busy_n = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
            i++;
            @(negedge clk);
        end
        busy_n = 1'b1;
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_end dout=%h ready=%b want 0000/1", dout, ready);
        end
    endtask

    task automatic test_ack();
        do_reset();
        for (int k = 0; k < 3; k++) send(12'(k), tlp(k));
        send_ack(2'b01, 12'd1);
        wait_ready("ack_purge");
        pulse_to();
        push_tlp(tlp(2));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL ack_replay dout=%h want=%h", dout, exp);
            end
            @(negedge clk);
        end
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL ack_end dout=%h ready=%b want 0000/1", dout, ready);
        end
    endtask

    task automatic test_nak();
        int t = 0;
        do_reset();
        for (int k = 0; k < 4; k++) send(12'(k), tlp(k));
        send_ack(2'b10, 12'd0);
        while (dout === 16'h0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 20) begin
            bad++;
            $display("FAIL nak_start timeout dout=%h want nonzero", dout);
        end
        for (int k = 1; k < 4; k++) push_tlp(tlp(k));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp || ready !== 1'b0) begin
                bad++;
                $display("FAIL nak_replay dout=%h ready=%b want %h/0", dout, ready, exp);
            end
            @(negedge clk);
        end
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL nak_end dout=%h ready=%b want 0000/1", dout, ready);
        end
        pulse_to();
        for (int k = 1; k < 4; k++) push_tlp(tlp(k));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL nak_held dout=%h want=%h", dout, exp);
            end
            @(negedge clk);
        end
        total++;
        if (dout !== 16'h0) begin
            bad++;
            $display("FAIL nak_held_end dout=%h want=0000", dout);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) send(12'(k), tlp(k));
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got=%b want=0", ready);
        end
        send_start(12'd8, tlp(8));
        total++;
        if (dout !== 16'h0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL full_drop dout=%h ready=%b want 0000/0", dout, ready);
        end
        send_ack(2'b01, 12'd7);
        wait_ready("full_ack");
        pulse_to();
        total++;
        if (dout !== 16'h0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL full_empty dout=%h ready=%b want 0000/1", dout, ready);
        end
    endtask

    task automatic test_priority();
        do_reset();
        send(12'd5, tlp(5));
        @(negedge clk);
        tim_out = 1'b1; we = 1'b1; seq = 12'd6; din = tlp(6);
        @(negedge clk);
        tim_out = 1'b0; we = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_tlp(tlp(5));
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                total++;
                if (dout !== exp) begin
                    bad++;
                    $display("FAIL prio_replay%0d dout=%h want=%h", r, dout, exp);
                end
                @(negedge clk);
            end
            total++;
            if (dout !== 16'h0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL prio_end%0d dout=%h ready=%b want 0000/1", r, dout, ready);
            end
            if (r == 0) pulse_to();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send(12'd4095, tlp(9));
        send_ack(2'b01, 12'd0);
        wait_ready("wrap_ack");
        pulse_to();
        total++;
        if (dout !== 16'h0) begin
            bad++;
            $display("FAIL wrap_release dout=%h want=0000", dout);
        end
        send(12'd10, tlp(10));
        send_ack(2'b01, 12'd9);
        wait_ready("wrap_noncover");
        pulse_to();
        push_tlp(tlp(10));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL wrap_kept dout=%h want=%h", dout, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        busy_n = 1'b1; reset_n = 1'b1; ack_nack = 2'b00; seq = '0;
        tim_out = 1'b0; we = 1'b0; din = '0;
        test_reset();
        test_store();
        test_stall();
        test_ack();
        test_nak();
        test_full();
        test_priority();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
